mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus/data width, legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, virtual address width.
REQ-003 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports address (in, ADDR_W), rt_value (in, DATA_W), mem_type (in, 2: NONE/LOAD/STOR), mem_size (in, 3: BYTE/HALF/FULL/DWORD), mem_signed (in, 1: 1 = sign-extend).
REQ-006 SHALL have outputs result (DATA_W, load data or address), stall (1, pipeline hold), done (1, one-cycle completion pulse), addr_err (1, misalignment), badvaddr (ADDR_W).
REQ-007 SHALL have bus outputs mem_req (1), mem_we (1), mem_wen (DATA_W/8), mem_addr (ADDR_W), mem_wdata (DATA_W), and bus inputs mem_gnt (1), mem_rvalid (1), mem_rdata (DATA_W).

Function
REQ-008 SHALL implement FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
- Stores skip WAIT: REQ -> DONE on mem_gnt.
REQ-009 SHALL accept an op in IDLE when mem_type != NONE, latching all operand inputs, then move to REQ.
REQ-010 SHALL drive stall = 1 in IDLE-with-op, REQ and WAIT, and stall = 0 in DONE and in IDLE with mem_type NONE.
REQ-011 SHALL hold mem_req, mem_addr, mem_we, mem_wen and mem_wdata registered and stable throughout REQ until mem_gnt = 1.
REQ-012 SHALL move REQ -> WAIT (load) on mem_gnt, and WAIT -> DONE on mem_rvalid; mem_rvalid outside WAIT SHALL be ignored.
REQ-013 SHALL register result in the DONE cycle and pulse done there; result SHALL hold until the next DONE.
REQ-014 SHALL form mem_addr = {3'b0, address[ADDR_W-4:0]} with the low log2(DATA_W/8) bits cleared.
REQ-015 SHALL replicate store data across lanes (byte x N, half x N/2, word x N/4) and set mem_wen to the addressed lanes only.
- FULL and DWORD with DATA_W = 64 select 4 and 8 lanes respectively.
REQ-016 SHALL select the addressed load lane and extend it to DATA_W: sign-extend when mem_signed = 1, zero-extend when 0.
REQ-017 SHALL treat DWORD as FULL when DATA_W = 32.
REQ-018 SHALL give minimum latency: store 3 cycles, load 4 cycles, counted from op accept to the DONE cycle inclusive.

Reset
REQ-019 SHALL on rst = 0 immediately force state IDLE and drive result = 0, done = 0, addr_err = 0, badvaddr = 0, mem_req = 0, mem_we = 0, mem_wen = 0.
REQ-020 SHALL abandon an in-flight transaction on reset mid-operation.
- A following mem_rvalid SHALL be ignored in IDLE.

Configuration
REQ-021 SHALL, with macro MEM_ALIGN_CHECK_EN defined, check alignment at accept.
- Fault cases: HALF with addr[0] set, FULL with addr[1:0] != 0, DWORD with addr[2:0] != 0.
- On fault: go IDLE -> DONE directly, with no mem_req, addr_err = 1 and badvaddr = address in DONE, and result = address.
REQ-022 SHALL, without MEM_ALIGN_CHECK_EN, tie addr_err and badvaddr to 0 and issue the access with the offending low address bits ignored.

Structure
REQ-023 SHALL take mem_type_t, mem_size_t, the FSM state enum and lane-count constants from shared package mem_pkg.
REQ-024 SHALL place lane steering and extraction in one combinational sub-module, mem_align, parametrised by DATA_W.

Verification
REQ-025 DATA_W = 32, LOAD BYTE signed, addr 0x0000_0003, rdata 0x80FF_FF00, gnt and rvalid one cycle after request -> result 0xFFFF_FF80, done in cycle 4, stall high for cycles 1-3.
REQ-026 DATA_W = 32, STOR HALF, addr 0x8000_0002, rt_value 0x1234_ABCD -> mem_addr 0x0000_0000, mem_wen 4'b1100, mem_wdata 0xABCD_ABCD, done in cycle 3.
REQ-027 DATA_W = 64, LOAD HALF unsigned, addr 0x...6, rdata 0xBEEF_0000_0000_0000 -> result 0x0000_0000_0000_BEEF.
REQ-028 mem_gnt held low for 5 cycles in REQ -> mem_req and all bus fields stable, stall held high, done delayed exactly 5 cycles.
REQ-029 MEM_ALIGN_CHECK_EN on, LOAD FULL at 0x0000_0002 -> no mem_req, addr_err = 1, badvaddr 0x0000_0002, done in cycle 2; macro off -> access to 0x0000_0000 completes normally.
REQ-030 rst asserted in WAIT, then mem_rvalid asserted after release -> all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, FSM state codes and lane helpers for the load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LOAD = 2'd1,
    MEM_STOR = 2'd2
  } mem_type_t;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_HALF  = 3'd1,
    SZ_FULL  = 3'd2,
    SZ_DWORD = 3'd3
  } mem_size_t;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_REQ  = 2'd1;
  localparam lsu_state_t ST_WAIT = 2'd2;
  localparam lsu_state_t ST_DONE = 2'd3;

  localparam int unsigned LANES_32 = 4;
  localparam int unsigned LANES_64 = 8;

  // DWORD collapses to a word on a 32-bit bus; unknown size codes act as a word.
  function automatic int unsigned size_bytes(mem_size_t size, int unsigned lanes);
    case (size)
      SZ_BYTE:  return 1;
      SZ_HALF:  return 2;
      SZ_DWORD: return (lanes == LANES_64) ? 8 : 4;
      default:  return 4;
    endcase
  endfunction

  function automatic logic misaligned(mem_size_t size, int unsigned lanes, logic [2:0] low);
    case (size_bytes(size, lanes))
      2:       return low[0];
      4:       return |low[1:0];
      8:       return |low;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store replication/byte enables and load lane extraction.
module mem_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]          offset,
  input  mem_size_t           size,
  input  logic                sign_ext,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] wen,
  output logic [DATA_W-1:0]   wdata_rep,
  output logic [DATA_W-1:0]   rdata_ext
);

  localparam int unsigned LANES = DATA_W / 8;

  int unsigned       nbytes;
  int unsigned       lane_off;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    nbytes    = size_bytes(size, LANES);
    // Low address bits below the access size are dropped, so the access stays naturally aligned.
    lane_off  = 32'(offset) & (LANES - 1) & ~(nbytes - 1);
    wen       = '0;
    wdata_rep = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wen[i]              = (i >= lane_off) && (i < lane_off + nbytes);
      wdata_rep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
    shifted   = rdata >> (8 * lane_off);
    rdata_ext = '0;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      rdata_ext[b] = (b < 8 * nbytes) ? shifted[b] : (sign_ext & shifted[8*nbytes-1]);
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding bus access, IDLE -> REQ -> WAIT -> DONE.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of aligning them down.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   rt_value,
  input  logic [1:0]          mem_type,
  input  logic [2:0]          mem_size,
  input  logic                mem_signed,
  output logic [DATA_W-1:0]   result,
  output logic                stall,
  output logic                done,
  output logic                addr_err,
  output logic [ADDR_W-1:0]   badvaddr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = (LANES == LANES_64) ? 3 : 2;

  lsu_state_t        state_q, state_d;
  mem_type_t         type_in;
  mem_size_t         size_in, size_q, size_sel;
  logic              idle, op_valid, is_store, fault;
  logic [ADDR_W-1:0] addr_q, bus_addr;
  logic              signed_q, store_q;
  logic [DATA_W-1:0] result_q, wdata_rep, rdata_ext;
  logic [LANES-1:0]  wen_calc;
  logic [2:0]        off_sel;
  logic              mem_req_q, mem_we_q;
  logic [LANES-1:0]  mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  assign type_in  = mem_type_t'(mem_type);
  assign size_in  = mem_size_t'(mem_size);
  assign idle     = (state_q == ST_IDLE);
  assign is_store = (type_in == MEM_STOR);
  assign op_valid = idle && (type_in == MEM_LOAD || type_in == MEM_STOR);
  assign bus_addr = {3'b000, address[ADDR_W-4:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_ALIGN_CHECK_EN
  assign fault = misaligned(size_in, LANES, address[2:0]);
`else
  assign fault = 1'b0;
`endif

  // Live operands steer lanes at accept; latched ones drive extraction later.
  assign off_sel  = idle ? address[2:0] : addr_q[2:0];
  assign size_sel = idle ? size_in : size_q;

  mem_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .offset   (off_sel),
    .size     (size_sel),
    .sign_ext (signed_q),
    .wdata    (rt_value),
    .rdata    (mem_rdata),
    .wen      (wen_calc),
    .wdata_rep(wdata_rep),
    .rdata_ext(rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_valid) state_d = fault ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_gnt) state_d = store_q ? ST_DONE : ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      store_q     <= 1'b0;
      result_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wen_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (op_valid) begin
        addr_q   <= address;
        size_q   <= size_in;
        signed_q <= mem_signed;
        store_q  <= is_store;
        if (fault) begin
          result_q <= DATA_W'(address);
        end else begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= is_store;
          mem_wen_q   <= is_store ? wen_calc : '0;
          mem_addr_q  <= bus_addr;
          mem_wdata_q <= wdata_rep;
        end
      end
      if (state_q == ST_REQ && mem_gnt) begin
        mem_req_q <= 1'b0;
        if (store_q) result_q <= DATA_W'(addr_q);
      end
      if (state_q == ST_WAIT && mem_rvalid) result_q <= rdata_ext;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic              addr_err_q;
  logic [ADDR_W-1:0] badvaddr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
      badvaddr_q <= '0;
    end else if (op_valid) begin
      addr_err_q <= fault;
      badvaddr_q <= fault ? address : '0;
    end else if (state_q == ST_DONE) begin
      addr_err_q <= 1'b0;
      badvaddr_q <= '0;
    end
  end

  assign addr_err = addr_err_q;
  assign badvaddr = badvaddr_q;
`else
  assign addr_err = 1'b0;
  assign badvaddr = '0;
`endif

  assign stall     = op_valid || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
